// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS
//   core. Owns the PC, fetches words from instruction memory over a req/ack
//   handshake, and presents the fetched word to decode. Hazard stalls hold the
//   stage. Redirects (taken branch, jump, JR) resolved downstream reload the PC
//   and flush IF/ID.
//
//   State      | meaning
//   -----------+---------------------------------------------------------------
//   ST_FETCH   | normal fetching; request outstanding when imem_req=1
//   ST_DISCARD | redirected while a request was in flight; drop its ack
//   ST_HOLD    | word arrived during a stall; parked in the hold buffer
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall               hold PC and IF/ID
//   redirect/_pc        load new PC (low two bits ignored), flush IF/ID
//   imem_req/_addr      fetch request and word-aligned address (registered)
//   imem_ack/_rdata     instruction word valid / data
//   ifid_*              IF/ID register: valid, instr, op/func slices, pc+4
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic                ifid_valid,
    output logic [31:0]         ifid_instr,
    output logic [5:0]          ifid_op,
    output logic [5:0]          ifid_func,
    output logic [PC_WIDTH-1:0] ifid_pc4
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    localparam logic [PC_WIDTH-1:0] WORD_BYTES = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(3));

    state_e                 state_q,      state_d;
    logic [PC_WIDTH-1:0]    pc_q,         pc_d;
    logic [PC_WIDTH-1:0]    req_addr_q,   req_addr_d;
    logic                   req_q,        req_d;
    logic                   ifid_valid_q, ifid_valid_d;
    logic [31:0]            ifid_instr_q, ifid_instr_d;
    logic [PC_WIDTH-1:0]    ifid_pc4_q,   ifid_pc4_d;
    logic [31:0]            hold_instr_q, hold_instr_d;
    logic [PC_WIDTH-1:0]    hold_addr_q,  hold_addr_d;

    logic                   accept;
    logic [PC_WIDTH-1:0]    req_pc4;
    logic [PC_WIDTH-1:0]    hold_pc4;

    // An ack only counts against an outstanding request.
    assign accept   = req_q & imem_ack;
    assign req_pc4  = req_addr_q + WORD_BYTES;
    assign hold_pc4 = hold_addr_q + WORD_BYTES;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        req_d        = req_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        hold_instr_d = hold_instr_q;
        hold_addr_d  = hold_addr_q;

        if (redirect) begin
            // Redirect beats stall: flush IF/ID and drop any parked word.
            pc_d         = redirect_pc & ALIGN_MASK;
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
            hold_instr_d = '0;
            hold_addr_d  = '0;
            case (state_q)
                ST_FETCH: begin
                    if (req_q && !imem_ack) begin
                        // Keep req stable on the stale address until its ack.
                        state_d = ST_DISCARD;
                    end else begin
                        req_d = 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (imem_ack) begin
                        state_d = ST_FETCH;
                        req_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                    req_d   = 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!req_q) begin
                        req_d      = 1'b1;
                        req_addr_d = pc_q;
                        if (!stall) begin
                            ifid_valid_d = 1'b0;
                            ifid_instr_d = '0;
                        end
                    end else if (accept) begin
                        if (stall) begin
                            hold_instr_d = imem_rdata;
                            hold_addr_d  = req_addr_q;
                            req_d        = 1'b0;
                            state_d      = ST_HOLD;
                        end else begin
                            // Chain straight into the next request so a
                            // zero-wait memory delivers one word per cycle.
                            ifid_valid_d = 1'b1;
                            ifid_instr_d = imem_rdata;
                            ifid_pc4_d   = req_pc4;
                            pc_d         = req_pc4;
                            req_addr_d   = req_pc4;
                        end
                    end else if (!stall) begin
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = '0;
                    end
                end
                ST_DISCARD: begin
                    // IF/ID is already empty from the redirect.
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = '0;
                    if (imem_ack) begin
                        state_d = ST_FETCH;
                        req_d   = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = hold_instr_q;
                        ifid_pc4_d   = hold_pc4;
                        pc_d         = hold_pc4;
                        state_d      = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            req_q        <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            hold_instr_q <= '0;
            hold_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            req_q        <= req_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            hold_instr_q <= hold_instr_d;
            hold_addr_q  <= hold_addr_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = req_addr_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_op    = ifid_instr_q[31:26];
    assign ifid_func  = ifid_instr_q[5:0];
    assign ifid_pc4   = ifid_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [5:0]  ifid_op;
    logic [5:0]  ifid_func;
    logic [31:0] ifid_pc4;

    // Second instance: reset PC at the top of the address space, always-ack memory.
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [5:0]  w_func;
    logic [31:0] w_pc4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Instruction memory contents as a function of the word address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
        .ifid_instr(ifid_instr), .ifid_op(ifid_op), .ifid_func(ifid_func),
        .ifid_pc4(ifid_pc4)
    );

    assign w_rdata = memw(w_addr);

    fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(1'b1), .imem_rdata(w_rdata), .ifid_valid(w_valid),
        .ifid_instr(w_instr), .ifid_op(w_op), .ifid_func(w_func),
        .ifid_pc4(w_pc4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ack;
        logic [1:0]  st;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic r, input logic [31:0] rpc,
                       input logic a, input logic [1:0] st, input logic rq,
                       input logic [31:0] addr, input logic v,
                       input logic [31:0] instr, input logic [31:0] pc4);
        vec_t t;
        t.stall = s; t.redirect = r; t.rpc = rpc; t.ack = a; t.st = st;
        t.req = rq; t.addr = addr; t.valid = v; t.instr = instr; t.pc4 = pc4;
        vecs.push_back(t);
    endtask

    localparam logic [1:0] F = 2'd0, D = 2'd1, H = 2'd2;

    logic [1:0]  st_now;
    logic [5:0]  exp_op, exp_func;
    logic [31:0] exp_next, rpc_r;
    logic        s_r, r_r, a_r;
    logic        pv, preq;
    logic [31:0] pi, pp, paddr;
    int          deliveries;

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;

        //  stall red rpc        ack st req addr         v  instr              pc4
        add(0, 0, 32'h0,   0, F, 1, 32'h000, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   1, F, 1, 32'h004, 1, memw(32'h000), 32'h004);
        add(0, 0, 32'h0,   1, F, 1, 32'h008, 1, memw(32'h004), 32'h008);
        add(0, 0, 32'h0,   0, F, 1, 32'h008, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   0, F, 1, 32'h008, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   1, F, 1, 32'h00C, 1, memw(32'h008), 32'h00C);
        add(1, 0, 32'h0,   1, H, 0, 32'h0,   1, memw(32'h008), 32'h00C);
        add(1, 0, 32'h0,   0, H, 0, 32'h0,   1, memw(32'h008), 32'h00C);
        add(1, 0, 32'h0,   0, H, 0, 32'h0,   1, memw(32'h008), 32'h00C);
        add(1, 0, 32'h0,   0, H, 0, 32'h0,   1, memw(32'h008), 32'h00C);
        add(0, 0, 32'h0,   0, F, 0, 32'h0,   1, memw(32'h00C), 32'h010);
        add(0, 0, 32'h0,   0, F, 1, 32'h010, 0, 32'h0,          32'h0);
        add(0, 1, 32'h103, 0, D, 1, 32'h010, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   0, D, 1, 32'h010, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   1, F, 0, 32'h0,   0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   0, F, 1, 32'h100, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   1, F, 1, 32'h104, 1, memw(32'h100), 32'h104);
        add(1, 1, 32'h040, 1, F, 0, 32'h0,   0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   0, F, 1, 32'h040, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   1, F, 1, 32'h044, 1, memw(32'h040), 32'h044);
        add(0, 1, 32'h200, 0, D, 1, 32'h044, 0, 32'h0,          32'h0);
        add(0, 1, 32'h300, 0, D, 1, 32'h044, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   1, F, 0, 32'h0,   0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   0, F, 1, 32'h300, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   1, F, 1, 32'h304, 1, memw(32'h300), 32'h304);
        add(1, 0, 32'h0,   1, H, 0, 32'h0,   1, memw(32'h300), 32'h304);
        add(0, 1, 32'h500, 0, F, 0, 32'h0,   0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   0, F, 1, 32'h500, 0, 32'h0,          32'h0);
        add(0, 0, 32'h0,   1, F, 1, 32'h504, 1, memw(32'h500), 32'h504);

        // Reset state (an ack during reset must be ignored).
        imem_ack = 1'b1;
        tick(); tick();
        st_now = dut.state_q;
        chk("rst_state", {30'd0, st_now}, {30'd0, F});
        chk("rst_req",   {31'd0, imem_req},   32'd0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc4",   ifid_pc4,   32'h0);
        imem_ack = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            imem_ack    = vecs[i].ack;
            imem_rdata  = memw(imem_addr);
            tick();
            st_now   = dut.state_q;
            exp_op   = vecs[i].instr[31:26];
            exp_func = vecs[i].instr[5:0];
            chk($sformatf("v%0d_state", i), {30'd0, st_now}, {30'd0, vecs[i].st});
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].req});
            if (vecs[i].req)
                chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_valid", i), {31'd0, ifid_valid}, {31'd0, vecs[i].valid});
            chk($sformatf("v%0d_instr", i), ifid_instr, vecs[i].instr);
            chk($sformatf("v%0d_opfunc", i), {20'd0, ifid_op, ifid_func}, {20'd0, exp_op, exp_func});
            if (vecs[i].valid)
                chk($sformatf("v%0d_pc4", i), ifid_pc4, vecs[i].pc4);
            if (i == 0) begin
                chk("wrap_req0",  {31'd0, w_req}, 32'd1);
                chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
            end
            if (i == 1) begin
                chk("wrap_valid", {31'd0, w_valid}, 32'd1);
                chk("wrap_instr", w_instr, memw(32'hFFFF_FFFC));
                chk("wrap_pc4",   w_pc4, 32'h0);
                chk("wrap_addr1", w_addr, 32'h0);
            end
        end

        // Reset arriving while a request is outstanding and acked.
        stall = 1'b0; redirect = 1'b0; imem_ack = 1'b1; imem_rdata = memw(imem_addr);
        reset = 1'b1;
        tick();
        st_now = dut.state_q;
        chk("midrst_state", {30'd0, st_now}, {30'd0, F});
        chk("midrst_req",   {31'd0, imem_req},   32'd0);
        chk("midrst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("midrst_instr", ifid_instr, 32'h0);
        chk("midrst_pc4",   ifid_pc4,   32'h0);
        reset = 1'b0; imem_ack = 1'b0;
        tick();
        chk("postrst_req",  {31'd0, imem_req}, 32'd1);
        chk("postrst_addr", imem_addr, 32'h0);

        // Random traffic against a program-order model: every fresh IF/ID word
        // must be the next sequential instruction, restarting at each redirect.
        exp_next   = 32'h0;
        deliveries = 0;
        for (int c = 0; c < 3000; c++) begin
            s_r   = ($urandom_range(3) == 0);
            r_r   = ($urandom_range(15) == 0);
            rpc_r = $urandom_range(32'h0000_0FFF);
            a_r   = imem_req && ($urandom_range(2) != 0);
            pv = ifid_valid; pi = ifid_instr; pp = ifid_pc4;
            preq = imem_req; paddr = imem_addr;
            stall = s_r; redirect = r_r; redirect_pc = rpc_r;
            imem_ack = a_r; imem_rdata = memw(imem_addr);
            tick();
            if (r_r) begin
                chk("rnd_flush_valid", {31'd0, ifid_valid}, 32'd0);
                chk("rnd_flush_instr", ifid_instr, 32'h0);
                exp_next = rpc_r & 32'hFFFF_FFFC;
            end else if (s_r) begin
                chk("rnd_stall_valid", {31'd0, ifid_valid}, {31'd0, pv});
                chk("rnd_stall_instr", ifid_instr, pi);
                chk("rnd_stall_pc4",   ifid_pc4,   pp);
            end else if (ifid_valid) begin
                chk("rnd_instr", ifid_instr, memw(exp_next));
                chk("rnd_pc4",   ifid_pc4,   exp_next + 32'd4);
                exp_next = exp_next + 32'd4;
                deliveries++;
            end else begin
                chk("rnd_bubble_instr", ifid_instr, 32'h0);
            end
            if (preq && !a_r) begin
                chk("rnd_req_hold",  {31'd0, imem_req}, 32'd1);
                chk("rnd_addr_hold", imem_addr, paddr);
            end
            if (imem_req)
                chk("rnd_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        end
        chk("rnd_progress", {31'd0, (deliveries >= 200)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Registers the fetched word into IF/ID, which drives op/func into the decode controller.
- Accepts hazard stalls, and accepts jump/branch/JR redirects resolved downstream.

Parameters:
- PC_WIDTH, 32, width of PC and address.
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect  in  1  taken branch/jump/JR: load redirect_pc, flush IF/ID
- redirect_pc  in  PC_WIDTH  target address; bits [1:0] ignored (treated as 0)
- imem_req  out  1  fetch request valid
- imem_addr  out  PC_WIDTH  fetch address, word aligned
- imem_ack  in  1  instruction word valid this cycle
- imem_rdata  in  32  instruction word
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_instr  out  32  IF/ID instruction (32'h0 when invalid)
- ifid_op  out  6  ifid_instr[31:26]
- ifid_func  out  6  ifid_instr[5:0]
- ifid_pc4  out  PC_WIDTH  address of ifid_instr + 4

Behaviour:
- All state is registered. op and func are pure slices of ifid_instr.
- Reset (sync; overrides everything, including mid-request):
  - pc=RESET_PC, state=FETCH, imem_req=0 in the reset cycle.
  - ifid_valid=0, ifid_instr=0, ifid_pc4=0, hold buffer cleared.
  - Any ack arriving during reset is ignored.
- FETCH state:
  - imem_req=1, imem_addr=req_addr. req_addr is a register loaded with pc when the request starts.
  - req_addr and imem_req stay stable until ack.
- On ack with no stall and no redirect:
  - ifid_instr<=imem_rdata, ifid_valid<=1, ifid_pc4<=req_addr+4, pc<=req_addr+4.
  - The next request issues the following cycle. A zero-wait memory sustains 1 instruction/cycle.
- Wait states (ack=0, no stall): ifid_valid<=0 and ifid_instr<=0 (bubble). pc unchanged.
- Stall:
  - IF/ID and pc are held.
  - If ack arrives while stalled, the word goes into the hold buffer, state=HOLD, imem_req=0.
  - In HOLD, when stall falls: IF/ID<=buffered word, pc<=buffered addr+4, state=FETCH. The new request issues the next cycle.
  - No instruction is lost or duplicated across a stall.
- Redirect (priority: reset > redirect > stall > ack):
  - pc<=redirect_pc & ~3, ifid_valid<=0, ifid_instr<=0, hold buffer discarded.
  - Request outstanding and ack=0 that cycle: state=DISCARD. req stays high on the stale addr. The next ack is dropped, then state=FETCH with the new pc.
  - Ack in the same cycle as redirect: that word is dropped, state=FETCH.
  - Redirect while in HOLD: buffer dropped, state=FETCH.
  - Redirect with stall both high: redirect wins. The flush happens and stall is ignored that cycle.
  - Redirect during DISCARD: pc updated again; still exactly one ack is dropped.
- PC arithmetic: req_addr+4 modulo 2^PC_WIDTH. 32'hFFFFFFFC+4 = 0, no flag.
- States: FETCH, DISCARD, HOLD. The encoding is free; the state must be observable in the testbench.

Test Plan:
- Reset then zero-wait memory, ack every cycle with rdata=addr-derived words -> imem_addr 0,4,8,C on consecutive cycles. ifid_valid=1 from cycle 2. ifid_pc4 = 4,8,C…
- Ack delayed 3 cycles on addr 8 -> imem_addr held at 8 for 3 cycles. IF/ID shows 2 bubbles (valid=0, instr=0), then the word with ifid_pc4=C.
- Ack at addr 4 while stall=1 for 4 cycles -> imem_req=0 during HOLD and IF/ID unchanged. After release, IF/ID = word@4 and the next imem_addr=8. No duplicate or missing word.
- Redirect to 32'h00000103 while the request at 0x10 is outstanding, ack 2 cycles later -> the stale word is dropped. Next imem_addr=0x100. ifid_valid=0 until the word@0x100 arrives.
- Redirect to 0x40 together with stall=1 and ack → IF/ID flushed (instr=0) and pc=0x40. The acked word never appears.
- RESET_PC=32'hFFFFFFFC -> after the first fetch, imem_addr=0 and ifid_pc4=0. Reset asserted mid-request -> outputs return to reset values the next cycle.
